// File: rtl/dot_stream_acc.sv
// Purpose: streaming unsigned dot product of N_ELEM element pairs (EW-bit elements, RW-bit result).
// Latency: out_valid rises the cycle after the final pair of a vector is accepted.
// Backpressure: in_ready drops while a result is held; the result is held until out_valid && out_ready.
// Option: define DOTSTREAM_ERR_EN to honour in_last and flag vector-length mismatches on a sticky out_err.
module dot_stream_acc #(
  parameter int N_ELEM = 10,
  parameter int EW     = 4,
  parameter int RW     = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [EW-1:0] in_a,
  input  logic [EW-1:0] in_b,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_result,
  output logic          out_err
);

  // Counter must be at least one bit wide so N_ELEM=1 still elaborates.
  localparam int CW = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

  state_t          state;
  logic [CW-1:0]   elemCnt;
  logic [RW-1:0]   accSum;
  logic [2*EW-1:0] prod;
  logic [RW-1:0]   sumNext;
  logic            accept;
  logic            lastElem;
  logic            closeVec;

  assign prod     = {{EW{1'b0}}, in_a} * {{EW{1'b0}}, in_b};
  assign sumNext  = accSum + {{(RW-2*EW){1'b0}}, prod};
  assign accept   = in_valid && in_ready;
  assign lastElem = (elemCnt == CW'(N_ELEM - 1));

`ifdef DOTSTREAM_ERR_EN
  logic errReg;
  logic errHit;

  // in_last closes the vector early; a length disagreement in either direction is an error.
  assign closeVec = lastElem || in_last;
  assign errHit   = (in_last && !lastElem) || (lastElem && !in_last);
  assign out_err  = errReg;

  // Sticky framing error, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errReg <= 1'b0;
    end else if (accept && errHit) begin
      errReg <= 1'b1;
    end
  end
`else
  logic unusedLast;

  // Vector length is fixed; in_last carries no meaning in this build.
  assign unusedLast = in_last;
  assign closeVec   = lastElem;
  assign out_err    = 1'b0;
`endif

  // Two-state accumulate/hold FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ACC;
      elemCnt    <= '0;
      accSum     <= '0;
      out_result <= '0;
      out_valid  <= 1'b0;
      in_ready   <= 1'b1;
    end else if (state == ACC) begin
      if (accept) begin
        if (closeVec) begin
          out_result <= sumNext;
          accSum     <= '0;
          elemCnt    <= '0;
          state      <= HOLD;
          in_ready   <= 1'b0;
          out_valid  <= 1'b1;
        end else begin
          accSum  <= sumNext;
          elemCnt <= elemCnt + CW'(1);
        end
      end
    end else begin
      // Input stays closed for the handshake cycle, giving N_ELEM+1 cycles per vector.
      if (out_ready) begin
        state     <= ACC;
        in_ready  <= 1'b1;
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/dot_stream_acc.md
DOT_STREAM_ACC -- requirements
Module: dot_stream_acc

Interface
REQ-001 Parameter N_ELEM, default 10, number of element pairs per vector; legal range 1..10.
REQ-002 Parameter EW, default 4, unsigned element width in bits; fixed at 4.
REQ-003 Parameter RW, default 12, result width in bits; fixed at 12.
REQ-004 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  element pair present.
REQ-008 in_ready  output  1  block accepts element pair.
REQ-009 in_a  input  EW  vector A element, unsigned.
REQ-010 in_b  input  EW  vector B element, unsigned.
REQ-011 in_last  input  1  final element marker; used only with DOTSTREAM_ERR_EN.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 out_result  output  RW  dot product of the completed vector.
REQ-015 out_err  output  1  sticky framing error; constant 0 without DOTSTREAM_ERR_EN.

Function
REQ-016 Element i of a vector SHALL be the i-th accepted pair, where acceptance is in_valid and in_ready both high at a rising clk edge.
REQ-017 The FSM SHALL have two states: ACC (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-018 Each product in_a*in_b SHALL be 8 bits unsigned, zero-extended to RW bits, and added to a RW-bit accumulator.
REQ-019 No overflow handling is required, since the maximum sum is 10*225 = 2250, which is less than 4096.
REQ-020 An element counter SHALL run 0..N_ELEM-1 and increment only on acceptance.
REQ-021 Acceptance with counter == N_ELEM-1 SHALL load out_result with the accumulator plus the current product, enter HOLD on the same edge, and clear the accumulator and counter.
REQ-022 Latency: out_valid SHALL rise in the cycle after the final element is accepted.
REQ-023 In HOLD, out_result SHALL stay stable until out_valid and out_ready are both high at an edge; the FSM SHALL then return to ACC.
REQ-024 In HOLD, in_ready SHALL be 0 even when out_ready is high, so back-to-back throughput is N_ELEM+1 cycles per vector.
REQ-025 Cycles with in_valid low in ACC SHALL leave the counter and accumulator unchanged, so gaps are allowed anywhere in a vector.
REQ-026 in_a, in_b and in_last SHALL be ignored when not accepted.
REQ-027 out_result SHALL hold its last value while in ACC; only out_valid qualifies it.
REQ-028 With N_ELEM=1, every accepted pair SHALL produce a result.

Reset
REQ-029 Asserting rst_n low SHALL immediately force state ACC, counter 0, accumulator 0, out_result 0, out_valid 0, in_ready 1 and out_err 0.
REQ-030 in_ready SHALL be 1 from the first edge after rst_n deasserts.
REQ-031 Reset mid-vector or in HOLD SHALL discard the partial sum or pending result; the next accepted pair is element 0.

Configuration
REQ-032 Macro DOTSTREAM_ERR_EN SHALL compile in length checking; without it, in_last is ignored and out_err is tied to 0.
REQ-033 With DOTSTREAM_ERR_EN, acceptance with in_last=1 and counter < N_ELEM-1 SHALL close the vector early exactly as in REQ-021, using the partial sum, and set out_err.
REQ-034 With DOTSTREAM_ERR_EN, acceptance with counter == N_ELEM-1 and in_last=0 SHALL close the vector normally and set out_err.
REQ-035 out_err SHALL stay set until reset.

Verification
REQ-036 Ten pairs (15,15) with out_ready=1 -> out_result=2250, out_valid high for 1 cycle, one cycle after the 10th acceptance.
REQ-037 Pairs a=i, b=1 for i=0..9, with in_valid low on alternate cycles -> out_result=45.
REQ-038 Vector of (2,3) x10 with out_ready=0 for 5 cycles -> in_ready=0 and out_result=60 held for those 5 cycles; the next vector is accepted after the handshake.
REQ-039 rst_n pulsed low after 4 accepted pairs of (15,15), then 10 pairs of (1,1) -> out_result=10.
REQ-040 DOTSTREAM_ERR_EN, in_last=1 on the 3rd pair of (1,2) -> out_result=6 and out_err=1; the following correct vector still yields the correct sum with out_err remaining 1.
REQ-041 Without DOTSTREAM_ERR_EN, the same stimulus as REQ-040 -> in_last ignored, the vector closes at the 10th pair, and out_err=0.
